// File: rtl/pl_branch_target_buffer.sv
// Direct-mapped fetch-stage BTB with next-PC selection and an IF/ID prediction register.
// Optional lookup/hit statistics counters are enabled with `define PL_BTB_STATS_EN.
module pl_branch_target_buffer #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] pc_if,
    input  logic        predicted_taken,
    output logic [31:0] next_pc,
    output logic        btb_hit,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        mispredict,
    input  logic [31:0] correct_pc,
    input  logic        btb_clear,
    output logic        pred_taken_id,
    output logic [31:0] pred_target_id
`ifdef PL_BTB_STATS_EN
    ,
    output logic [31:0] lookup_count,
    output logic [31:0] hit_count
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("ENTRIES must be a power of two and at least 2");
    end

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_write;
    logic             pred_taken;
    logic [31:0]      seq_pc;
    logic [31:0]      pred_pc;

    // Word-offset bits carry no information for a word-aligned fetch.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc_if[1:0], upd_pc[1:0]};

    assign lk_idx  = pc_if[IDX_W+1:2];
    assign lk_tag  = pc_if[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    // Lookup sees the table as it was before this cycle's update.
    always_comb begin
        btb_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken = btb_hit && predicted_taken;
        seq_pc     = pc_if + 32'd4;
        pred_pc    = pred_taken ? target_q[lk_idx] : seq_pc;
        next_pc    = mispredict ? correct_pc : pred_pc;
    end

    // Not-taken resolutions leave the table untouched; clear and reset drop any write.
    assign upd_write = enable && upd_valid && upd_taken && !btb_clear && !reset;

    always_ff @(posedge clk) begin
        if (reset || btb_clear) begin
            valid_q <= '0;
        end else if (upd_write) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_write) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    // IF/ID boundary: a redirect flushes the slot even while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (reset || mispredict) begin
            pred_taken_id  <= 1'b0;
            pred_target_id <= 32'd0;
        end else if (enable) begin
            pred_taken_id  <= pred_taken;
            pred_target_id <= pred_pc;
        end
    end

`ifdef PL_BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lookup_count <= 32'd0;
            hit_count    <= 32'd0;
        end else if (enable) begin
            if (lookup_count != 32'hFFFF_FFFF) begin
                lookup_count <= lookup_count + 32'd1;
            end
            if (btb_hit && hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pl_branch_target_buffer.md
Name: pl_branch_target_buffer

Overview:
- Fetch-stage branch target buffer with next-PC selection, directly upstream of the 2-bit direction predictor.
- Each cycle it looks up the fetch PC in a direct-mapped table.
- It combines a hit with the predictor's predicted_taken to choose next_pc.
- It registers the prediction into the IF/ID boundary for later resolution.
- The EX stage writes resolved targets back into the table and can override next_pc on a misprediction.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of two, minimum 2.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
- TAG_W, 30-IDX_W, stored tag width.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- enable  input  1  pipeline advance; 0 = stall, which holds registered state and blocks updates
- pc_if  input  32  current fetch PC, word aligned
- predicted_taken  input  1  direction prediction from the 2-bit predictor
- next_pc  output  32  PC to load into the PC register
- btb_hit  output  1  combinational lookup hit for pc_if
- upd_valid  input  1  EX resolved a branch this cycle
- upd_pc  input  32  PC of the resolved branch
- upd_target  input  32  resolved branch target
- upd_taken  input  1  resolved direction
- mispredict  input  1  EX redirect request
- correct_pc  input  32  redirect PC, valid with mispredict
- btb_clear  input  1  invalidate all entries
- pred_taken_id  output  1  registered prediction for the instruction now in ID
- pred_target_id  output  32  registered predicted next PC for the instruction now in ID

Behaviour:
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Storage: per entry, valid (1), tag (TAG_W) and target (32).
- Lookup (combinational):
  - btb_hit = valid[idx(pc_if)] && tag[idx] == tag(pc_if).
  - Lookup always reads pre-update contents; no write-through.
- next_pc priority:
  1. mispredict=1 → correct_pc.
  2. btb_hit && predicted_taken → target[idx(pc_if)].
  3. otherwise → pc_if + 4, 32-bit wrap (0xFFFFFFFC+4 = 0x00000000).
  - next_pc is combinational and is independent of enable; the PC register applies the stall.
- Update (posedge clk, when enable && upd_valid && !btb_clear):
  - upd_taken=1 → write tag(upd_pc) and upd_target at idx(upd_pc), set valid. This overwrites any conflicting entry.
  - upd_taken=0 → no table change; the existing entry is retained.
- Clear: btb_clear=1 at a posedge clears every valid bit regardless of enable. Clear wins over a simultaneous update.
- IF/ID register (posedge clk), evaluated in priority order:
  - reset → pred_taken_id=0, pred_target_id=0.
  - mispredict → pred_taken_id=0, pred_target_id=0 (flush). Applies even if enable=0.
  - enable → pred_taken_id = btb_hit && predicted_taken; pred_target_id = next_pc as computed at priority levels 2 and 3.
  - otherwise hold.
- Reset: all valid bits cleared, pred_taken_id=0, pred_target_id=0. Tag and target arrays are not cleared.
- Reset asserted mid-update: the update is dropped.
- Same-cycle update and lookup at the same index: lookup returns the old entry; the new entry is visible the next cycle.

Optional Feature:
- Macro: PL_BTB_STATS_EN.
- Defined: adds outputs lookup_count[31:0] and hit_count[31:0].
  - When enable=1, lookup_count increments every cycle.
  - When enable && btb_hit, hit_count increments.
  - Both counters saturate at 0xFFFFFFFF and clear on reset (btb_clear does not clear them).
- Undefined: the ports and counters are absent, and the remaining behaviour is unchanged.

Test Plan:
- Cold lookup after reset: pc_if=0x00000040, predicted_taken=1 → btb_hit=0, next_pc=0x00000044, pred_taken_id=0 next cycle.
- Install then hit: update upd_pc=0x40, upd_target=0x100, upd_taken=1. Next cycle pc_if=0x40, predicted_taken=1 → btb_hit=1, next_pc=0x100, pred_target_id=0x100 after the edge. Same cycle with predicted_taken=0 → next_pc=0x44.
- Alias conflict: with 0x40 installed, update upd_pc=0x80 (same idx for ENTRIES=16 since bits[5:2]=0), upd_target=0x200 → lookup 0x40 misses, lookup 0x80 hits with target 0x200.
- Mispredict priority/flush: BTB hit on 0x40 with mispredict=1, correct_pc=0x44, enable=0 → next_pc=0x44, pred_taken_id=0 and pred_target_id=0 next cycle.
- Clear vs update: btb_clear=1 together with update of 0x40 → lookup 0x40 misses next cycle. Stall (enable=0) with upd_valid → no table write, pred_* held.
- Wrap-around and stats: pc_if=0xFFFFFFFC miss → next_pc=0x00000000. With PL_BTB_STATS_EN, 3 enabled cycles with 1 hit → lookup_count=3, hit_count=1.
